car_alarm_sequencer: RTL and testbench
======================================

CAR_ALARM_SEQUENCER -- requirements
Module: car_alarm_sequencer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, cycles the alarm condition must hold before chiming; legal range 1..255.
REQ-002 Parameter CHIME_ON_CYCLES, default 3, buzzer-high cycles per chime; legal range 1..255.
REQ-003 Parameter CHIME_OFF_CYCLES, default 2, buzzer-low cycles between chimes; legal range 1..255.
REQ-004 Parameter MAX_CHIMES, default 5, chimes before auto-silence; legal range 1..15.
REQ-005 Port clk, input, 1, single clock; all state updates on its rising edge.
REQ-006 Port reset_L, input, 1, asynchronous active-low reset.
REQ-007 Port CarLightsOnSign, input, 1, lights switched on.
REQ-008 Port OpenDoorSign, input, 1, driver door open.
REQ-009 Port IgnitionSignalOn, input, 1, ignition on.
REQ-010 Port AcknowledgeSign, input, 1, driver silence button, one-cycle or level.
REQ-011 Port CarAlarmSignal, output, 1, registered buzzer drive.
REQ-012 Port AlarmActive, output, 1, high in every state except IDLE.
REQ-013 Port ChimeCount, output, 4, completed chimes since leaving IDLE.

Function
REQ-014 cond = CarLightsOnSign AND OpenDoorSign AND NOT IgnitionSignalOn, sampled directly each edge.
REQ-015 States: IDLE, QUALIFY, CHIME_ON, CHIME_OFF, SILENCED; one 8-bit cycle counter shared by all timed states, cleared on every state change.
REQ-016 IDLE: cond high -> QUALIFY, counter 0.
REQ-017 QUALIFY: cond high and counter == DEBOUNCE_CYCLES-1 -> CHIME_ON; otherwise counter increments.
REQ-018 Latency: CarAlarmSignal rises after the edge DEBOUNCE_CYCLES edges after the first edge sampling cond high.
REQ-019 CHIME_ON: CarAlarmSignal high for exactly CHIME_ON_CYCLES cycles, then -> CHIME_OFF and ChimeCount increments.
REQ-020 CHIME_OFF: CarAlarmSignal low for exactly CHIME_OFF_CYCLES cycles, then -> SILENCED if ChimeCount == MAX_CHIMES, else -> CHIME_ON.
REQ-021 ChimeCount never exceeds MAX_CHIMES, holds in SILENCED, and clears to 0 on entry to IDLE.
REQ-022 AcknowledgeSign high in CHIME_ON or CHIME_OFF -> SILENCED next edge; ChimeCount holds, and a partially completed chime does not count.
REQ-023 AcknowledgeSign is ignored in IDLE, QUALIFY and SILENCED.
REQ-024 cond low in any non-IDLE state -> IDLE next edge, and this takes priority over AcknowledgeSign and over timer expiry on the same edge.
REQ-025 SILENCED: CarAlarmSignal low; remain until cond low -> IDLE; re-arming requires a new full debounce.
REQ-026 CarAlarmSignal is high only in CHIME_ON, registered, and glitch-free.

Reset
REQ-027 reset_L low immediately forces IDLE, counter 0, CarAlarmSignal 0, AlarmActive 0, ChimeCount 0 (and LightsOffRequest 0 when present), including mid-chime.
REQ-028 After reset_L rises, the first edge with cond high starts QUALIFY normally.

Configuration
REQ-029 Macro CAR_ALARM_AUTO_LIGHTS_OFF_EN defined: adds output LightsOffRequest (1 bit), high only in SILENCED entered via MAX_CHIMES exhaustion, cleared on entry to IDLE or on reset.
REQ-030 Macro undefined: LightsOffRequest port and logic are absent, and all other behaviour is identical.

Verification (defaults)
REQ-031 cond held from edge 0 -> CarAlarmSignal high after edges 4-6, low after 7-8, five chimes total, then SILENCED with ChimeCount=5 and LightsOffRequest=1 if enabled.
REQ-032 cond high for 3 edges then low -> CarAlarmSignal stays 0, returns to IDLE, AlarmActive 0 after the drop edge.
REQ-033 AcknowledgeSign pulse during the 2nd CHIME_ON -> CarAlarmSignal 0 next edge, ChimeCount=1, LightsOffRequest=0.
REQ-034 IgnitionSignalOn rises during CHIME_OFF of chime 3 -> IDLE next edge, ChimeCount=0.
REQ-035 AcknowledgeSign and cond drop on the same edge -> IDLE, not SILENCED.
REQ-036 reset_L pulsed low mid-CHIME_ON between edges -> all outputs 0 without waiting for clk; full debounce again afterwards.

Source files
------------

// File: rtl/car_alarm_sequencer_if.sv
// Signal bundle between the car body inputs and the alarm sequencer.
// LightsOffRequest exists only when CAR_ALARM_AUTO_LIGHTS_OFF_EN is defined.
interface car_alarm_sequencer_if;
  logic       CarLightsOnSign;
  logic       OpenDoorSign;
  logic       IgnitionSignalOn;
  logic       AcknowledgeSign;
  logic       CarAlarmSignal;
  logic       AlarmActive;
  logic [3:0] ChimeCount;
`ifdef CAR_ALARM_AUTO_LIGHTS_OFF_EN
  logic       LightsOffRequest;
`endif

  modport master (
    output CarLightsOnSign, OpenDoorSign, IgnitionSignalOn, AcknowledgeSign,
    input  CarAlarmSignal, AlarmActive, ChimeCount
`ifdef CAR_ALARM_AUTO_LIGHTS_OFF_EN
    , input LightsOffRequest
`endif
  );

  modport slave (
    input  CarLightsOnSign, OpenDoorSign, IgnitionSignalOn, AcknowledgeSign,
    output CarAlarmSignal, AlarmActive, ChimeCount
`ifdef CAR_ALARM_AUTO_LIGHTS_OFF_EN
    , output LightsOffRequest
`endif
  );
endinterface

// File: rtl/car_alarm_sequencer.sv
// Lights-on/door-open chime sequencer: debounce, timed chimes, auto-silence.
// Optional macro CAR_ALARM_AUTO_LIGHTS_OFF_EN adds LightsOffRequest.
module car_alarm_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES  = 4,
  parameter int unsigned CHIME_ON_CYCLES  = 3,
  parameter int unsigned CHIME_OFF_CYCLES = 2,
  parameter int unsigned MAX_CHIMES       = 5
) (
  input  logic                  clk,
  input  logic                  reset_L,
  car_alarm_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, QUALIFY, CHIME_ON, CHIME_OFF, SILENCED} state_e;

  localparam logic [7:0] DEB_LAST  = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] ON_LAST   = 8'(CHIME_ON_CYCLES - 1);
  localparam logic [7:0] OFF_LAST  = 8'(CHIME_OFF_CYCLES - 1);
  localparam logic [3:0] CHIME_MAX = 4'(MAX_CHIMES);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] chime_q, chime_d;
  logic       alarm_q, alarm_d;
  logic       cond, ack, off_done;

  assign cond     = bus.CarLightsOnSign & bus.OpenDoorSign & ~bus.IgnitionSignalOn;
  assign ack      = bus.AcknowledgeSign;
  assign off_done = (state_q == CHIME_OFF) && (cnt_q == OFF_LAST);

`ifdef CAR_ALARM_AUTO_LIGHTS_OFF_EN
  logic lights_q, lights_d;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      chime_q  <= '0;
      alarm_q  <= 1'b0;
`ifdef CAR_ALARM_AUTO_LIGHTS_OFF_EN
      lights_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      chime_q  <= chime_d;
      alarm_q  <= alarm_d;
`ifdef CAR_ALARM_AUTO_LIGHTS_OFF_EN
      lights_q <= lights_d;
`endif
    end
  end

  // Priority in every active state: cond drop, then acknowledge, then timer.
  always_comb begin
    // NOTE: defaults up front keep every path assigned, so no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (cond) state_d = QUALIFY;
      QUALIFY:   if (!cond) state_d = IDLE;
                 else if (cnt_q == DEB_LAST) state_d = CHIME_ON;
      CHIME_ON:  if (!cond) state_d = IDLE;
                 else if (ack) state_d = SILENCED;
                 else if (cnt_q == ON_LAST) state_d = CHIME_OFF;
      CHIME_OFF: if (!cond) state_d = IDLE;
                 else if (ack) state_d = SILENCED;
                 else if (off_done) state_d = (chime_q == CHIME_MAX) ? SILENCED : CHIME_ON;
      SILENCED:  if (!cond) state_d = IDLE;
      default:   state_d = IDLE;
    endcase

    if (state_d != state_q || state_q == IDLE || state_q == SILENCED) cnt_d = '0;
    else                                                             cnt_d = cnt_q + 8'd1;

    chime_d = chime_q;
    if (state_d == IDLE) chime_d = '0;
    else if (state_q == CHIME_ON && state_d == CHIME_OFF) chime_d = chime_q + 4'd1;
  end

  // Outputs are decoded from the next state and registered to stay glitch-free.
  always_comb begin
    alarm_d = (state_d == CHIME_ON);
`ifdef CAR_ALARM_AUTO_LIGHTS_OFF_EN
    lights_d = lights_q;
    if (state_d == IDLE) lights_d = 1'b0;
    else if (state_d == SILENCED && off_done && !ack) lights_d = 1'b1;
`endif
  end

  assign bus.CarAlarmSignal   = alarm_q;
  assign bus.AlarmActive      = (state_q != IDLE);
  assign bus.ChimeCount       = chime_q;
`ifdef CAR_ALARM_AUTO_LIGHTS_OFF_EN
  assign bus.LightsOffRequest = lights_q;
`endif

endmodule

// File: tb/tb_car_alarm_sequencer.sv
// Scoreboard bench for car_alarm_sequencer: a run-length reference model
// pushes expected outputs per edge; they are popped and compared after the edge.
module tb_car_alarm_sequencer;

  localparam int D   = 4;
  localparam int ON  = 3;
  localparam int OFF = 2;
  localparam int MX  = 5;
  localparam int P   = ON + OFF;

  typedef struct {
    logic       alarm;
    logic       active;
    logic [3:0] count;
    logic       lights;
  } exp_t;

  logic clk = 1'b0;
  logic reset_L = 1'b0;
  car_alarm_sequencer_if bus_if ();

  car_alarm_sequencer #(
    .DEBOUNCE_CYCLES (D),
    .CHIME_ON_CYCLES (ON),
    .CHIME_OFF_CYCLES(OFF),
    .MAX_CHIMES      (MX)
  ) dut (
    .clk    (clk),
    .reset_L(reset_L),
    .bus    (bus_if)
  );

  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   edge_no = 0;
  exp_t sb[$];

  // Reference model: r = edges since cond was first seen high (-1 when idle).
  int r      = -1;
  bit acked  = 1'b0;
  int frozen = 0;

  task automatic check(input string tag, input int obs, input int exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got %0d, expected %0d", tag, edge_no, obs, exp_v);
    end
  endtask

  function automatic int count_of(input int rr);
    int t;
    if (rr < D) return 0;
    t = rr - D;
    if (t / P >= MX) return MX;
    return t / P + (((t % P) >= ON) ? 1 : 0);
  endfunction

  function automatic bit chiming();
    return !acked && r >= D && ((r - D) / P) < MX;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e = '{alarm: 1'b0, active: 1'b0, count: 4'd0, lights: 1'b0};
    if (r >= 0) begin
      e.active = 1'b1;
      if (acked) e.count = 4'(frozen);
      else begin
        e.count  = 4'(count_of(r));
        e.alarm  = r >= D && ((r - D) / P) < MX && ((r - D) % P) < ON;
        e.lights = r >= D && ((r - D) / P) >= MX;
      end
    end
    return e;
  endfunction

  task automatic model_edge(input bit cond, input bit ack);
    if (!cond) begin
      r = -1;
      acked = 1'b0;
    end else if (r < 0) r = 0;
    else if (acked) r = r;
    else if (chiming() && ack) begin
      acked  = 1'b1;
      frozen = count_of(r);
    end else r++;
  endtask

  task automatic set_in(input bit lights, input bit door, input bit ign, input bit ack);
    bus_if.CarLightsOnSign  = lights;
    bus_if.OpenDoorSign     = door;
    bus_if.IgnitionSignalOn = ign;
    bus_if.AcknowledgeSign  = ack;
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    edge_no++;
    model_edge(bus_if.CarLightsOnSign & bus_if.OpenDoorSign & ~bus_if.IgnitionSignalOn,
               bus_if.AcknowledgeSign);
    sb.push_back(model_out());
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      check("alarm",  int'(bus_if.CarAlarmSignal), int'(e.alarm));
      check("active", int'(bus_if.AlarmActive),    int'(e.active));
      check("count",  int'(bus_if.ChimeCount),     int'(e.count));
`ifdef CAR_ALARM_AUTO_LIGHTS_OFF_EN
      check("lights", int'(bus_if.LightsOffRequest), int'(e.lights));
`endif
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_alarm"},  int'(bus_if.CarAlarmSignal), 0);
    check({tag, "_active"}, int'(bus_if.AlarmActive),    0);
    check({tag, "_count"},  int'(bus_if.ChimeCount),     0);
`ifdef CAR_ALARM_AUTO_LIGHTS_OFF_EN
    check({tag, "_lights"}, int'(bus_if.LightsOffRequest), 0);
`endif
  endtask

  initial begin
    set_in(0, 0, 0, 0);
    #2 check_zero("reset");
    #10 reset_L = 1'b1;

    // Full sequence: five chimes then silence; a few idle edges first.
    run(2);
    set_in(1, 1, 0, 0);
    run(34);
    check("silenced_count", int'(bus_if.ChimeCount), MX);
    set_in(1, 0, 0, 0);
    run(2);

    // Short qualify: cond for 3 edges then drop, with ack ignored meanwhile.
    set_in(1, 1, 0, 1);
    run(3);
    set_in(1, 0, 0, 0);
    run(2);

    // Acknowledge during the second chime's on-phase.
    set_in(1, 1, 0, 0);
    run(10);
    set_in(1, 1, 0, 1);
    run(1);
    set_in(1, 1, 0, 0);
    run(4);
    check("ack_count", int'(bus_if.ChimeCount), 1);
    set_in(0, 1, 0, 1);
    run(2);

    // Ignition during chime 3 off-phase.
    set_in(1, 1, 0, 0);
    run(18);
    set_in(1, 1, 1, 0);
    run(2);

    // Acknowledge and cond drop on the same edge.
    set_in(1, 1, 0, 0);
    run(6);
    set_in(1, 0, 0, 1);
    run(1);
    check("ack_drop_active", int'(bus_if.AlarmActive), 0);
    set_in(0, 0, 0, 0);
    run(1);

    // Async reset mid chime-on, then full debounce again.
    set_in(1, 1, 0, 0);
    run(5);
    check("pre_rst_alarm", int'(bus_if.CarAlarmSignal), 1);
    #2 reset_L = 1'b0;
    #1 check_zero("rst_async");
    r = -1;
    acked = 1'b0;
    #2 reset_L = 1'b1;
    run(8);

    // Randomised inputs biased toward long cond-high runs.
    for (int i = 0; i < 300; i++) begin
      set_in(1'b1, $urandom_range(0, 39) != 0, $urandom_range(0, 59) == 0,
             $urandom_range(0, 24) == 0);
      step();
    end

    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
